temperature_monitor_controller: RTL and testbench

TEMPERATURE_MONITOR_CONTROLLER -- requirements
Module: temperature_monitor_controller

---
 rtl/temperature_monitor_controller_pkg.sv | 26 ++
 rtl/temperature_monitor_controller_detector.sv | 26 ++
 rtl/temperature_monitor_controller.sv | 171 +++++++++++++++++
 tb/tb_temperature_monitor_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temperature_monitor_controller_pkg.sv
// Shared definitions for the temperature monitor controller:
// FSM encoding, parameter defaults, reset config and detector limits.
package temperature_monitor_controller_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_DEBOUNCE    = 3;
    localparam int DEF_SCAN_DIV    = 16;
    localparam int DEF_ACK_TIMEOUT = 15;

    localparam logic [4:0] RST_BASE_TEMP = 5'b10000;
    localparam logic [3:0] RST_TEMP_COEF = 4'b1000;

    // Sensor code 8 is the zero point; coefficient 8 is unity gain (scaled by 1/8).
    localparam logic signed [4:0] SENSOR_MID = 5'sd8;
    localparam logic signed [9:0] LOW_LIMIT  = 10'sd10;
    localparam logic signed [9:0] HIGH_LIMIT = 10'sd22;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REQ,
        EVAL,
        UPDATE
    } ctrlStateT;

endpackage

// File: rtl/temperature_monitor_controller_detector.sv
// Combinational abnormality detector: estimates temperature from a calibrated
// sensor code and flags values outside the normal window.
module temperatureAbnormalityDetector
    import temperature_monitor_controller_pkg::*;
(
    input  logic [4:0] baseTemp,
    input  logic [3:0] tempCoef,
    input  logic [3:0] sensorVal,
    output logic       low,
    output logic       high
);

    logic signed [4:0] offset;
    logic signed [9:0] scaled;
    logic signed [9:0] tempEst;

    // tempEst = base + ((sensor - 8) * coef) / 8, arithmetic shift floors negatives
    always_comb begin
        offset  = $signed({1'b0, sensorVal}) - SENSOR_MID;
        scaled  = 10'(offset) * 10'($signed({1'b0, tempCoef}));
        tempEst = $signed({5'b00000, baseTemp}) + (scaled >>> 3);
        low     = (tempEst < LOW_LIMIT);
        high    = (tempEst > HIGH_LIMIT);
    end

endmodule

// File: rtl/temperature_monitor_controller.sv
// Round-robin temperature scan controller: requests one sample per channel,
// runs it through a shared detector and debounces per-channel alarms.
module temperature_monitor_controller
    import temperature_monitor_controller_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int SCAN_DIV    = DEF_SCAN_DIV,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfgWe,
    input  logic [4:0]        cfgBaseTemp,
    input  logic [3:0]        cfgTempCoef,
    output logic              sampleReq,
    output logic [1:0]        sampleCh,
    input  logic              sampleAck,
    input  logic [3:0]        sampleData,
    output logic [NUM_CH-1:0] lowAlarm,
    output logic [NUM_CH-1:0] highAlarm,
    output logic [NUM_CH-1:0] sensorFault,
    input  logic [NUM_CH-1:0] clearAlarm,
    output logic              alarmIrq,
    output logic              busy
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int WAIT_W = $clog2(SCAN_DIV + 1);
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SCAN_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

    ctrlStateT         state, stateNext;
    logic [CH_W-1:0]   ch;
    logic [WAIT_W-1:0] waitCnt;
    logic [TO_W-1:0]   reqCnt;
    logic              skipSample;
    logic [4:0]        shadowBase, activeBase;
    logic [3:0]        shadowCoef, activeCoef;
    logic [3:0]        sampleReg;
    logic              lowReg, highReg;
    logic              detLow, detHigh;
    logic [DB_W-1:0]   hiCnt [NUM_CH];
    logic [DB_W-1:0]   loCnt [NUM_CH];
    logic [DB_W-1:0]   hiNext, loNext;
    logic [NUM_CH-1:0] setLow, setHigh, setFault;
    logic              ackTimeout, roundStart;

    function automatic logic [DB_W-1:0] satInc(input logic [DB_W-1:0] v);
        return (v >= DB_MAX) ? DB_MAX : v + DB_W'(1);
    endfunction

    assign ackTimeout = (state == REQ) && !sampleAck && (reqCnt == TO_LAST);
    assign roundStart = (state == WAIT) && enable && (waitCnt == WAIT_LAST);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (enable) stateNext = WAIT;
            WAIT: begin
                if (!enable)         stateNext = IDLE;
                else if (roundStart) stateNext = REQ;
            end
            REQ: begin
                if (sampleAck)       stateNext = EVAL;
                else if (ackTimeout) stateNext = UPDATE;
            end
            EVAL:    stateNext = UPDATE;
            UPDATE: begin
                if (ch != LAST_CH) stateNext = REQ;
                else if (enable)   stateNext = WAIT;
                else               stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // High takes precedence when the detector reports both directions.
    always_comb begin
        hiNext   = '0;
        loNext   = '0;
        setLow   = '0;
        setHigh  = '0;
        setFault = '0;
        if (highReg)     hiNext = satInc(hiCnt[ch]);
        else if (lowReg) loNext = satInc(loCnt[ch]);
        if (state == UPDATE && !skipSample) begin
            setHigh[ch] = (hiNext == DB_MAX);
            setLow[ch]  = (loNext == DB_MAX);
        end
        if (ackTimeout) setFault[ch] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            waitCnt     <= '0;
            reqCnt      <= '0;
            skipSample  <= 1'b0;
            shadowBase  <= RST_BASE_TEMP;
            shadowCoef  <= RST_TEMP_COEF;
            activeBase  <= RST_BASE_TEMP;
            activeCoef  <= RST_TEMP_COEF;
            lowAlarm    <= '0;
            highAlarm   <= '0;
            sensorFault <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hiCnt[i] <= '0;
                loCnt[i] <= '0;
            end
        end else begin
            state   <= stateNext;
            waitCnt <= (state == WAIT && stateNext == WAIT) ? waitCnt + WAIT_W'(1) : '0;
            reqCnt  <= (state == REQ && stateNext == REQ) ? reqCnt + TO_W'(1) : '0;
            if (roundStart)
                ch <= '0;
            else if (state == UPDATE && stateNext == REQ)
                ch <= ch + CH_W'(1);
            if (state == REQ) begin
                if (sampleAck)       skipSample <= 1'b0;
                else if (ackTimeout) skipSample <= 1'b1;
            end
            if (cfgWe) begin
                shadowBase <= cfgBaseTemp;
                shadowCoef <= cfgTempCoef;
            end
            // Active config only changes between rounds.
            if (state == IDLE || roundStart) begin
                activeBase <= shadowBase;
                activeCoef <= shadowCoef;
            end
            if (state == UPDATE && !skipSample) begin
                hiCnt[ch] <= hiNext;
                loCnt[ch] <= loNext;
            end
            lowAlarm    <= (lowAlarm    & ~clearAlarm) | setLow;
            highAlarm   <= (highAlarm   & ~clearAlarm) | setHigh;
            sensorFault <= (sensorFault & ~clearAlarm) | setFault;
        end
    end

    // Sample and detector result registers carry data only, no reset needed.
    always_ff @(posedge clk) begin
        if (state == REQ && sampleAck) sampleReg <= sampleData;
        if (state == EVAL) begin
            lowReg  <= detLow;
            highReg <= detHigh;
        end
    end

    temperatureAbnormalityDetector uDetector (
        .baseTemp  (activeBase),
        .tempCoef  (activeCoef),
        .sensorVal (sampleReg),
        .low       (detLow),
        .high      (detHigh)
    );

    assign sampleReq = (state == REQ);
    assign sampleCh  = 2'(ch);
    assign busy      = (state != IDLE);
    assign alarmIrq  = (|lowAlarm) | (|highAlarm) | (|sensorFault);

endmodule

// File: tb/tb_temperature_monitor_controller.sv
// Directed testbench for temperature_monitor_controller with a scripted
// sensor-mux responder and hand-computed expectations.
module tb_temperature_monitor_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cfgWe;
    logic [4:0] cfgBaseTemp;
    logic [3:0] cfgTempCoef;
    logic       sampleReq;
    logic [1:0] sampleCh;
    logic       sampleAck;
    logic [3:0] sampleData;
    logic [3:0] lowAlarm;
    logic [3:0] highAlarm;
    logic [3:0] sensorFault;
    logic [3:0] clearAlarm;
    logic       alarmIrq;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [3:0] hiAtUpd  [4];
    logic [3:0] hiAfter  [4];
    logic       irqAfter [4];

    temperature_monitor_controller dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfgWe       (cfgWe),
        .cfgBaseTemp (cfgBaseTemp),
        .cfgTempCoef (cfgTempCoef),
        .sampleReq   (sampleReq),
        .sampleCh    (sampleCh),
        .sampleAck   (sampleAck),
        .sampleData  (sampleData),
        .lowAlarm    (lowAlarm),
        .highAlarm   (highAlarm),
        .sensorFault (sensorFault),
        .clearAlarm  (clearAlarm),
        .alarmIrq    (alarmIrq),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Serves one scan round. dv holds one nibble per channel (ch0 in [3:0]).
    task automatic doRound(input logic [15:0] dv, input logic [3:0] noAck,
                           input int clrCh, input bit cfgWrite, output int waitCycles);
        int n;
        int hi;
        waitCycles = 0;
        for (int c = 0; c < 4; c++) begin
            n = 0;
            while (sampleReq !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (c == 0) waitCycles = n;
            total++;
            if (sampleReq !== 1'b1) begin
                bad++;
                $display("FAIL reqWait ch%0d: sampleReq=%b required 1", c, sampleReq);
                return;
            end
            total++;
            if (sampleCh !== 2'(c)) begin
                bad++;
                $display("FAIL chOrder: sampleCh=%0d required %0d", sampleCh, c);
            end
            if (noAck[c]) begin
                hi = 1;
                while (sampleReq === 1'b1 && hi < 40) begin
                    @(negedge clk);
                    if (sampleReq === 1'b1) hi++;
                end
                total++;
                if (hi != 15) begin
                    bad++;
                    $display("FAIL reqLength ch%0d: %0d cycles required 15", c, hi);
                end
                total++;
                if (sensorFault[c] !== 1'b1) begin
                    bad++;
                    $display("FAIL faultSet ch%0d: sensorFault=%b required bit set", c, sensorFault);
                end
            end else begin
                sampleAck  = 1'b1;
                sampleData = dv[c*4 +: 4];
                if (cfgWrite && c == 1) begin
                    cfgWe       = 1'b1;
                    cfgBaseTemp = 5'b00000;
                    cfgTempCoef = 4'b0000;
                end
                @(negedge clk);
                sampleAck  = 1'b0;
                sampleData = 4'h0;
                cfgWe      = 1'b0;
                total++;
                if (sampleReq !== 1'b0) begin
                    bad++;
                    $display("FAIL reqDrop ch%0d: sampleReq=%b required 0", c, sampleReq);
                end
                @(negedge clk);
                hiAtUpd[c] = highAlarm;
                if (clrCh == c) clearAlarm[c] = 1'b1;
                @(negedge clk);
                clearAlarm  = 4'b0000;
                hiAfter[c]  = highAlarm;
                irqAfter[c] = alarmIrq;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; cfgWe = 1'b0; cfgBaseTemp = 5'd0; cfgTempCoef = 4'd0;
        sampleAck = 1'b0; sampleData = 4'd0; clearAlarm = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (sampleReq !== 1'b0) begin bad++; $display("FAIL rstReq: got %b required 0", sampleReq); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstBusy: got %b required 0", busy); end
        total++;
        if (alarmIrq !== 1'b0) begin bad++; $display("FAIL rstIrq: got %b required 0", alarmIrq); end
        total++;
        if ({lowAlarm, highAlarm, sensorFault} !== 12'h000) begin
            bad++;
            $display("FAIL rstAlarms: got %h required 000", {lowAlarm, highAlarm, sensorFault});
        end
    endtask

    task automatic test_normal_scan();
        int w;
        enable = 1'b1;
        doRound(16'h8888, 4'b0000, -1, 1'b0, w);
        total++;
        if (w != 17) begin bad++; $display("FAIL firstReqLatency: %0d cycles required 17", w); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL scanBusy: got %b required 1", busy); end
        doRound(16'h8888, 4'b0000, -1, 1'b0, w);
        total++;
        if ({lowAlarm, highAlarm, sensorFault, alarmIrq} !== 13'h0000) begin
            bad++;
            $display("FAIL normalNoAlarm: got %h required 0000", {lowAlarm, highAlarm, sensorFault, alarmIrq});
        end
    endtask

    task automatic test_high_debounce();
        int w;
        doRound(16'h8F88, 4'b0000, -1, 1'b0, w);
        doRound(16'h8F88, 4'b0000, -1, 1'b0, w);
        total++;
        if (highAlarm !== 4'b0000) begin bad++; $display("FAIL hiAfter2: got %b required 0000", highAlarm); end
        doRound(16'h8F88, 4'b0000, -1, 1'b0, w);
        total++;
        if (hiAtUpd[2] !== 4'b0000) begin bad++; $display("FAIL hiLatency1: got %b required 0000", hiAtUpd[2]); end
        total++;
        if (hiAfter[2] !== 4'b0100) begin bad++; $display("FAIL hiLatency2: got %b required 0100", hiAfter[2]); end
        total++;
        if (irqAfter[2] !== 1'b1) begin bad++; $display("FAIL hiIrq: got %b required 1", irqAfter[2]); end
        clearAlarm = 4'b0100;
        @(negedge clk);
        clearAlarm = 4'b0000;
        total++;
        if (highAlarm !== 4'b0000) begin bad++; $display("FAIL hiClear: got %b required 0000", highAlarm); end
        total++;
        if (alarmIrq !== 1'b0) begin bad++; $display("FAIL irqFall: got %b required 0", alarmIrq); end
        doRound(16'h8888, 4'b0000, -1, 1'b0, w);
        doRound(16'h8F88, 4'b0000, -1, 1'b0, w);
        doRound(16'h8888, 4'b0000, -1, 1'b0, w);
        doRound(16'h8F88, 4'b0000, -1, 1'b0, w);
        total++;
        if ({lowAlarm, highAlarm} !== 8'h00) begin
            bad++;
            $display("FAIL brokenPattern: got %h required 00", {lowAlarm, highAlarm});
        end
    endtask

    task automatic test_clear_collision();
        int w;
        doRound(16'h8F88, 4'b0000, -1, 1'b0, w);
        doRound(16'h8F88, 4'b0000, 2, 1'b0, w);
        total++;
        if (hiAfter[2] !== 4'b0100) begin bad++; $display("FAIL setWins: got %b required 0100", hiAfter[2]); end
        clearAlarm = 4'b0100;
        @(negedge clk);
        clearAlarm = 4'b0000;
        total++;
        if (highAlarm !== 4'b0000) begin bad++; $display("FAIL lateClear: got %b required 0000", highAlarm); end
        total++;
        if (alarmIrq !== 1'b0) begin bad++; $display("FAIL irqAfterClear: got %b required 0", alarmIrq); end
    endtask

    task automatic test_ack_timeout();
        int w;
        doRound(16'h8888, 4'b0010, -1, 1'b0, w);
        total++;
        if (sensorFault !== 4'b0010) begin bad++; $display("FAIL faultVec: got %b required 0010", sensorFault); end
        total++;
        if (alarmIrq !== 1'b1) begin bad++; $display("FAIL faultIrq: got %b required 1", alarmIrq); end
        clearAlarm = 4'b0010;
        @(negedge clk);
        clearAlarm = 4'b0000;
        total++;
        if ({sensorFault, alarmIrq} !== 5'b00000) begin
            bad++;
            $display("FAIL faultClear: got %b required 00000", {sensorFault, alarmIrq});
        end
    endtask

    task automatic test_cfg_switch();
        int w;
        doRound(16'h8888, 4'b0000, -1, 1'b1, w);
        total++;
        if ({lowAlarm, highAlarm} !== 8'h00) begin
            bad++;
            $display("FAIL oldCfgRound: got %h required 00", {lowAlarm, highAlarm});
        end
        doRound(16'h8888, 4'b0000, -1, 1'b0, w);
        doRound(16'h8888, 4'b0000, -1, 1'b0, w);
        total++;
        if (lowAlarm !== 4'b0000) begin bad++; $display("FAIL newCfgRound2: got %b required 0000", lowAlarm); end
        doRound(16'h8888, 4'b0000, -1, 1'b0, w);
        total++;
        if (lowAlarm !== 4'b1111) begin bad++; $display("FAIL newCfgRound3: got %b required 1111", lowAlarm); end
        total++;
        if (alarmIrq !== 1'b1) begin bad++; $display("FAIL lowIrq: got %b required 1", alarmIrq); end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (sampleReq !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sampleReq !== 1'b1) begin bad++; $display("FAIL midReqWait: sampleReq=%b required 1", sampleReq); end
        rst = 1'b1;
        #1;
        total++;
        if (sampleReq !== 1'b0) begin bad++; $display("FAIL asyncReqDrop: got %b required 0", sampleReq); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL asyncIdle: busy=%b required 0", busy); end
        total++;
        if ({lowAlarm, highAlarm, sensorFault, alarmIrq} !== 13'h0000) begin
            bad++;
            $display("FAIL asyncAlarms: got %h required 0000", {lowAlarm, highAlarm, sensorFault, alarmIrq});
        end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idleAfterRst: busy=%b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_normal_scan();
        test_high_debounce();
        test_clear_collision();
        test_ack_timeout();
        test_cfg_switch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
